// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, raw x/y counters, delayed
// hs/vs/blank aligned to a two-stage draw path, and RGB332 -> 24-bit expansion.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int CLK_DIV    = 2,
  parameter int SYNC_DELAY = 2
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [7:0]  RGB_in,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        pixelEn,
  output logic        startOfFrame,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blankN,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b
);

  localparam int HT_I = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT_I = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] X_LAST = 11'(HT_I - 1);
  localparam logic [10:0] Y_LAST = 11'(VT_I - 1);
  localparam logic [10:0] HA     = 11'(H_ACTIVE);
  localparam logic [10:0] VA     = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  // Divider is one bit wide even when CLK_DIV=1 so it stays a legal vector.
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
  } sync_t;

  logic [DW-1:0] div;
  logic          x_last, y_last;
  sync_t         raw;
  sync_t         sync_pipe [1:SYNC_DELAY];
  logic [7:0]    rgb_q;
  logic [2:0]    r3, g3;
  logic [1:0]    b2;

  assign pixelEn = (div == DIV_MAX);
  assign x_last  = (pixelX == X_LAST);
  assign y_last  = (pixelY == Y_LAST);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)      div <= '0;
    else if (pixelEn) div <= '0;
    else              div <= div + DW'(1);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pixelX <= '0;
      pixelY <= '0;
    end else if (pixelEn) begin
      if (x_last) begin
        pixelX <= '0;
        pixelY <= y_last ? 11'd0 : pixelY + 11'd1;
      end else begin
        pixelX <= pixelX + 11'd1;
      end
    end
  end

  // Registered off the wrap condition so the pulse lands on the first (0,0)
  // cycle and never at reset release.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) startOfFrame <= 1'b0;
    else         startOfFrame <= pixelEn && x_last && y_last;
  end

  always_comb begin
    raw     = '{hs: 1'b1, vs: 1'b1, act: 1'b0};
    raw.hs  = !((pixelX >= HS_BEG) && (pixelX < HS_END));
    raw.vs  = !((pixelY >= VS_BEG) && (pixelY < VS_END));
    raw.act = (pixelX < HA) && (pixelY < VA);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 1; i <= SYNC_DELAY; i++)
        sync_pipe[i] <= '{hs: 1'b1, vs: 1'b1, act: 1'b0};
    end else begin
      sync_pipe[1] <= raw;
      for (int i = 2; i <= SYNC_DELAY; i++)
        sync_pipe[i] <= sync_pipe[i-1];
    end
  end

  assign vga_hs     = sync_pipe[SYNC_DELAY].hs;
  assign vga_vs     = sync_pipe[SYNC_DELAY].vs;
  assign vga_blankN = sync_pipe[SYNC_DELAY].act;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) rgb_q <= '0;
    else         rgb_q <= RGB_in;
  end

  // Bit replication spreads each channel across the full 0..255 range.
  assign r3 = rgb_q[7:5];
  assign g3 = rgb_q[4:2];
  assign b2 = rgb_q[1:0];

  assign vga_r = vga_blankN ? {r3, r3, r3[2:1]} : 8'h00;
  assign vga_g = vga_blankN ? {g3, g3, g3[2:1]} : 8'h00;
  assign vga_b = vga_blankN ? {b2, b2, b2, b2}  : 8'h00;

endmodule
